// File: rtl/interp_linear_ds_feed.sv
// rtl/interp_linear_ds_feed.sv - linear interpolator feeding the delta-sigma modulator; optional macro INTERP_UNDERRUN_CNT_EN adds underrun_cnt
module interp_linear_ds_feed #(
  parameter int DATA_W     = 14,
  parameter int LOG2_RATIO = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              underrun
`ifdef INTERP_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int ACC_W   = DATA_W + LOG2_RATIO + 1;
  localparam int DELTA_W = DATA_W + 1;
  localparam logic [LOG2_RATIO-1:0] PHASE_LAST = '1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]                state;
  logic                      hold_valid;
  logic signed [DATA_W-1:0]  hold_data;
  logic signed [DATA_W-1:0]  prev;
  logic signed [DATA_W-1:0]  cur;
  logic signed [ACC_W-1:0]   acc;
  logic [LOG2_RATIO-1:0]     phase;

  logic signed [DELTA_W-1:0] delta;
  logic signed [ACC_W-1:0]   delta_ext;
  logic signed [ACC_W-1:0]   hold_scaled;
  logic signed [ACC_W-1:0]   cur_scaled;
  logic                      unused_acc_msb;

  // Slope of the current period; zero whenever prev and cur coincide (first period, hold)
  assign delta       = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
  assign delta_ext   = {{LOG2_RATIO{delta[DELTA_W-1]}}, delta};
  assign hold_scaled = {hold_data[DATA_W-1], hold_data, {LOG2_RATIO{1'b0}}};
  assign cur_scaled  = {cur[DATA_W-1], cur, {LOG2_RATIO{1'b0}}};

  // The acc sign bit only guards the intermediate sum; the output slice never needs it
  assign unused_acc_msb = acc[ACC_W-1];

  assign in_ready  = !hold_valid;
  assign out_valid = (state != ST_EMPTY);
  assign data_out  = (state == ST_EMPTY) ? '0 : acc[LOG2_RATIO +: DATA_W];

  // Input buffer, ramp accumulator and period sequencing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      prev       <= '0;
      cur        <= '0;
      acc        <= '0;
      phase      <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (in_valid && in_ready) begin
        hold_data  <= data_in;
        hold_valid <= 1'b1;
      end
      case (state)
        ST_EMPTY: begin
          if (hold_valid) begin
            prev       <= hold_data;
            cur        <= hold_data;
            acc        <= hold_scaled;
            phase      <= '0;
            hold_valid <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          phase <= phase + 1'b1;
          acc   <= acc + delta_ext;
          if (phase == PHASE_LAST) begin
            acc  <= cur_scaled;
            prev <= cur;
            if (hold_valid) begin
              cur        <= hold_data;
              phase      <= '0;
              hold_valid <= 1'b0;
            end else begin
              underrun <= 1'b1;
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_valid) begin
            prev       <= cur;
            cur        <= hold_data;
            acc        <= cur_scaled;
            phase      <= '0;
            hold_valid <= 1'b0;
            state      <= ST_RUN;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef INTERP_UNDERRUN_CNT_EN
  // Saturating tally of periods that ended with nothing buffered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if ((state == ST_RUN) && (phase == PHASE_LAST) && !hold_valid &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
